// File: rtl/rtc_calendar_counter.sv
// Real-time clock and calendar. A prescaler divides clk down to a 1 Hz tick.
// Binary year/month/day/hour/minute/second fields advance on that tick and can be loaded as one validated set.
module rtc_calendar_counter #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int YEAR_BASE = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic [7:0] set_year,
  input  logic [7:0] set_month,
  input  logic [7:0] set_day,
  input  logic [7:0] set_hour,
  input  logic [7:0] set_minute,
  input  logic [7:0] set_second,
  output logic [7:0] year,
  output logic [7:0] month,
  output logic [7:0] day,
  output logic [7:0] hour,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic       tick_1hz,
  output logic       set_err
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  // Leap years are the ones where (YEAR_BASE + year) is a multiple of 4; no century exception inside one base century.
  localparam logic [1:0] BASE_PHASE = 2'(YEAR_BASE % 4);

  logic [PW-1:0] presc;
  logic          sec_tick;
  logic          set_valid;
  logic          load;
  logic [7:0]    dim_cur;
  logic [7:0]    dim_set;
  logic [7:0]    next_year;
  logic [7:0]    next_month;
  logic [7:0]    next_day;
  logic [7:0]    next_hour;
  logic [7:0]    next_minute;
  logic [7:0]    next_second;

  function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [7:0] y);
    logic [1:0] phase;
    phase = y[1:0] + BASE_PHASE;
    case (m)
      8'd4, 8'd6, 8'd9, 8'd11: days_in_month = 8'd30;
      8'd2:                    days_in_month = (phase == 2'd0) ? 8'd29 : 8'd28;
      default:                 days_in_month = 8'd31;
    endcase
  endfunction

  assign sec_tick = (presc == PRESC_MAX);
  assign dim_cur  = days_in_month(month, year);
  assign dim_set  = days_in_month(set_month, set_year);

  assign set_valid = (set_year <= 8'd99) &&
                     (set_month >= 8'd1) && (set_month <= 8'd12) &&
                     (set_day >= 8'd1) && (set_day <= dim_set) &&
                     (set_hour <= 8'd23) &&
                     (set_minute <= 8'd59) &&
                     (set_second <= 8'd59);
  assign load = set_en && set_valid;

  // Full carry chain from the current registers so every field lands on the same edge.
  always_comb begin
    next_second = second;
    next_minute = minute;
    next_hour   = hour;
    next_day    = day;
    next_month  = month;
    next_year   = year;
    if (second >= 8'd59) begin
      next_second = 8'd0;
      if (minute >= 8'd59) begin
        next_minute = 8'd0;
        if (hour >= 8'd23) begin
          next_hour = 8'd0;
          if (day >= dim_cur) begin
            next_day = 8'd1;
            if (month >= 8'd12) begin
              next_month = 8'd1;
              next_year  = (year >= 8'd99) ? 8'd0 : year + 8'd1;
            end else begin
              next_month = month + 8'd1;
            end
          end else begin
            next_day = day + 8'd1;
          end
        end else begin
          next_hour = hour + 8'd1;
        end
      end else begin
        next_minute = minute + 8'd1;
      end
    end else begin
      next_second = second + 8'd1;
    end
  end

  // A valid load overrides a coincident tick; a rejected load lets the tick through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc    <= '0;
      year     <= 8'd0;
      month    <= 8'd1;
      day      <= 8'd1;
      hour     <= 8'd0;
      minute   <= 8'd0;
      second   <= 8'd0;
      tick_1hz <= 1'b0;
      set_err  <= 1'b0;
    end else begin
      tick_1hz <= sec_tick && !load;
      set_err  <= set_en && !set_valid;
      if (load) begin
        presc  <= '0;
        year   <= set_year;
        month  <= set_month;
        day    <= set_day;
        hour   <= set_hour;
        minute <= set_minute;
        second <= set_second;
      end else begin
        presc <= sec_tick ? '0 : presc + PW'(1);
        if (sec_tick) begin
          year   <= next_year;
          month  <= next_month;
          day    <= next_day;
          hour   <= next_hour;
          minute <= next_minute;
          second <= next_second;
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_calendar_counter.sv
// Scoreboard bench for rtc_calendar_counter at CLK_HZ=4.
// Expected snapshots are queued as stimulus is applied and popped once the DUT has updated.
module tb_rtc_calendar_counter;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] mo;
    logic [7:0] d;
    logic [7:0] h;
    logic [7:0] mi;
    logic [7:0] s;
    logic       t;
    logic       e;
  } snap_t;

  logic       clk;
  logic       rst;
  logic       set_en;
  logic [7:0] set_year, set_month, set_day, set_hour, set_minute, set_second;
  logic [7:0] year, month, day, hour, minute, second;
  logic       tick_1hz, set_err;

  snap_t obs;
  snap_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  rtc_calendar_counter #(.CLK_HZ(4), .YEAR_BASE(2000)) dut (
    .clk(clk), .rst(rst), .set_en(set_en),
    .set_year(set_year), .set_month(set_month), .set_day(set_day),
    .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second),
    .year(year), .month(month), .day(day), .hour(hour), .minute(minute), .second(second),
    .tick_1hz(tick_1hz), .set_err(set_err)
  );

  assign obs = {year, month, day, hour, minute, second, tick_1hz, set_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t mk(input int y, input int mo, input int d, input int h,
                               input int mi, input int s, input bit t, input bit e);
    mk = {8'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s), t, e};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    set_en = 1'b0;
    rst = 1'b0;
    step();
    #2;
    rst = 1'b1;
  endtask

  task automatic drive_set(input int y, input int mo, input int d, input int h, input int mi, input int s);
    set_year = 8'(y); set_month = 8'(mo); set_day = 8'(d);
    set_hour = 8'(h); set_minute = 8'(mi); set_second = 8'(s);
    set_en = 1'b1;
    step();
    set_en = 1'b0;
  endtask

  task automatic test_reset;
    snap_t got, e;
    rst = 1'b1;
    set_en = 1'b0;
    {set_year, set_month, set_day, set_hour, set_minute, set_second} = '0;
    #2 rst = 1'b0;
    #10;
    exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0));
    got = obs; e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h expected %h", got, e);
    end
    #1 rst = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      exp_q.push_back(mk(0, 1, 1, 0, 0, c / 4, (c % 4) == 0, 0));
      step();
      got = obs; e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("[TB] FAIL count_cycle_%0d: got %h expected %h", c, got, e);
      end
    end
  endtask

  // Load a time, then expect the loaded value held for three cycles and the rolled value on the fourth.
  task automatic test_set_then_tick(input string nm,
                                    input int y, input int mo, input int d, input int h, input int mi, input int s,
                                    input snap_t after);
    snap_t got, e;
    do_reset();
    exp_q.push_back(mk(y, mo, d, h, mi, s, 0, 0));
    drive_set(y, mo, d, h, mi, s);
    got = obs; e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("[TB] FAIL %s_load: got %h expected %h", nm, got, e);
    end
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back((i < 4) ? mk(y, mo, d, h, mi, s, 0, 0) : after);
      step();
      got = obs; e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("[TB] FAIL %s_step%0d: got %h expected %h", nm, i, got, e);
      end
    end
  endtask

  task automatic test_invalid_set;
    snap_t got, e;
    do_reset();
    step();
    step();
    exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1));
    drive_set(5, 4, 31, 10, 10, 10);
    got = obs; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("[TB] FAIL inv_apr31: got %h expected %h", got, e); end
    exp_q.push_back(mk(0, 1, 1, 0, 0, 1, 1, 0));
    step();
    got = obs; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("[TB] FAIL inv_phase_kept: got %h expected %h", got, e); end
    exp_q.push_back(mk(0, 1, 1, 0, 0, 1, 0, 1));
    drive_set(5, 6, 15, 24, 0, 0);
    got = obs; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("[TB] FAIL inv_hour24: got %h expected %h", got, e); end
    exp_q.push_back(mk(0, 1, 1, 0, 0, 1, 0, 1));
    drive_set(5, 0, 10, 1, 1, 1);
    got = obs; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("[TB] FAIL inv_month0: got %h expected %h", got, e); end
    exp_q.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0));
    step();
    got = obs; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("[TB] FAIL err_single_pulse: got %h expected %h", got, e); end
    exp_q.push_back(mk(0, 1, 1, 0, 0, 2, 1, 0));
    step();
    got = obs; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("[TB] FAIL inv_next_tick: got %h expected %h", got, e); end
    exp_q.push_back(mk(0, 1, 1, 0, 0, 2, 0, 1));
    drive_set(23, 2, 29, 0, 0, 0);
    got = obs; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("[TB] FAIL inv_feb29_nonleap: got %h expected %h", got, e); end
  endtask

  task automatic test_set_wins;
    snap_t got, e;
    do_reset();
    step(); step(); step();
    exp_q.push_back(mk(10, 5, 15, 12, 34, 56, 0, 0));
    drive_set(10, 5, 15, 12, 34, 56);
    got = obs; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("[TB] FAIL set_wins_load: got %h expected %h", got, e); end
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(mk(10, 5, 15, 12, 34, (i == 4) ? 57 : 56, i == 4, 0));
      step();
      got = obs; e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("[TB] FAIL set_wins_step%0d: got %h expected %h", i, got, e); end
    end
    do_reset();
    step(); step(); step();
    exp_q.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1));
    drive_set(5, 13, 1, 0, 0, 0);
    got = obs; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("[TB] FAIL invalid_plus_tick: got %h expected %h", got, e); end
  endtask

  task automatic test_reset_mid_count;
    snap_t got, e;
    do_reset();
    exp_q.push_back(mk(0, 1, 1, 10, 20, 30, 0, 0));
    drive_set(0, 1, 1, 10, 20, 30);
    got = obs; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("[TB] FAIL mid_load: got %h expected %h", got, e); end
    step();
    step();
    #2 rst = 1'b0;
    exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0));
    #1;
    got = obs; e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("[TB] FAIL async_reset: got %h expected %h", got, e); end
    step();
    #2 rst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(mk(0, 1, 1, 0, 0, (i == 4) ? 1 : 0, i == 4, 0));
      step();
      got = obs; e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("[TB] FAIL post_reset_step%0d: got %h expected %h", i, got, e); end
    end
  endtask

  initial begin
    test_reset();
    test_set_then_tick("rollover_99", 99, 12, 31, 23, 59, 59, mk(0, 1, 1, 0, 0, 0, 1, 0));
    test_set_then_tick("leap_24", 24, 2, 28, 23, 59, 59, mk(24, 2, 29, 0, 0, 0, 1, 0));
    test_set_then_tick("nonleap_23", 23, 2, 28, 23, 59, 59, mk(23, 3, 1, 0, 0, 0, 1, 0));
    test_set_then_tick("leap_feb29", 24, 2, 29, 23, 59, 59, mk(24, 3, 1, 0, 0, 0, 1, 0));
    test_invalid_set();
    test_set_wins();
    test_reset_mid_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
